// File: rtl/sha256_sched_pkg.sv
// Shared types, widths and arbitration helper for the SHA-256 nonce scheduler.
package sha256_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } sched_state_t;

  localparam int NONCE_W   = 32;
  localparam int ADDR_W    = 16;
  localparam int MAX_CORES = 16;
  localparam int IDX_W     = 4;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_CORES-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sha256_nonce_scheduler_if.sv
// Core-bank handshake plus the single result write port of the nonce scheduler.
interface sha256_nonce_scheduler_if
  import sha256_sched_pkg::*;
#(
  parameter int NUM_CORES = 8
) ();

  logic [NUM_CORES-1:0]         core_start;
  logic [NONCE_W*NUM_CORES-1:0] core_nonce;
  logic [NUM_CORES-1:0]         core_done;
  logic [NONCE_W*NUM_CORES-1:0] core_h0;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [NONCE_W-1:0]           mem_write_data;

  modport master (
    output core_start, core_nonce, mem_we, mem_addr, mem_write_data,
    input  core_done, core_h0
  );

  modport slave (
    input  core_start, core_nonce, mem_we, mem_addr, mem_write_data,
    output core_done, core_h0
  );

endinterface

// File: rtl/sha256_sched_prio_enc.sv
// Lowest-index-wins priority encoder used for dispatch and write arbitration.
module sha256_sched_prio_enc
  import sha256_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [MAX_CORES-1:0] req_pad;

  always_comb begin
    req_pad = '0;
    req_pad[WIDTH-1:0] = req;
  end

  assign grant = lowest_set(req_pad);
  assign valid = |req;

endmodule

// File: rtl/sha256_nonce_scheduler.sv
// Hands nonces to a bank of SHA-256 cores and serialises their h0 results
// into memory at output_addr + nonce.
module sha256_nonce_scheduler
  import sha256_sched_pkg::*;
#(
  parameter int NUM_CORES  = 8,
  parameter int NUM_NONCES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] output_addr,
  output logic              done,
  output logic              mem_clk,
  sha256_nonce_scheduler_if.master bus
);

  sched_state_t         state;
  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] armed;
  logic [NUM_CORES-1:0] res_valid;
  logic [NUM_CORES-1:0] dispatch_req;
  logic [NONCE_W-1:0]   nonce_q   [NUM_CORES];
  logic [ADDR_W-1:0]    res_nonce [NUM_CORES];
  logic [NONCE_W-1:0]   res_data  [NUM_CORES];
  logic [NONCE_W-1:0]   next_nonce;
  logic [NONCE_W-1:0]   write_count;
  logic [ADDR_W-1:0]    base_addr;
  logic [IDX_W-1:0]     disp_idx;
  logic [IDX_W-1:0]     wr_idx;
  logic                 disp_valid;
  logic                 wr_valid;
  logic                 nonces_left;

  assign mem_clk     = clk;
  assign nonces_left = next_nonce < NONCE_W'(NUM_NONCES);

  // A core is only handed work when it is idle and its previous result has drained.
  always_comb begin
    dispatch_req = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      dispatch_req[i] = (state == RUN) && nonces_left && !busy[i] &&
                        !res_valid[i] && bus.core_done[i];
    end
  end

  sha256_sched_prio_enc #(.WIDTH(NUM_CORES)) u_dispatch_enc (
    .req   (dispatch_req),
    .grant (disp_idx),
    .valid (disp_valid)
  );

  sha256_sched_prio_enc #(.WIDTH(NUM_CORES)) u_write_enc (
    .req   (res_valid),
    .grant (wr_idx),
    .valid (wr_valid)
  );

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_nonce
    assign bus.core_nonce[g*NONCE_W +: NONCE_W] = nonce_q[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      done               <= 1'b1;
      bus.core_start     <= '0;
      bus.mem_we         <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_write_data <= '0;
      busy               <= '0;
      armed              <= '0;
      res_valid          <= '0;
      next_nonce         <= '0;
      write_count        <= '0;
      base_addr          <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        nonce_q[i]   <= '0;
        res_nonce[i] <= '0;
        res_data[i]  <= '0;
      end
    end else begin
      bus.core_start <= '0;
      bus.mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_addr   <= output_addr;
            busy        <= '0;
            armed       <= '0;
            res_valid   <= '0;
            next_nonce  <= '0;
            write_count <= '0;
            done        <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (write_count == NONCE_W'(NUM_NONCES)) state <= FINISH;
          // core_done stays high for one cycle after a start, so only a 1->0->1
          // sequence while busy counts as a finished job.
          for (int i = 0; i < NUM_CORES; i++) begin
            if (busy[i] && !bus.core_done[i]) armed[i] <= 1'b1;
            if (busy[i] && armed[i] && bus.core_done[i]) begin
              res_data[i]  <= bus.core_h0[i*NONCE_W +: NONCE_W];
              res_nonce[i] <= nonce_q[i][ADDR_W-1:0];
              res_valid[i] <= 1'b1;
              busy[i]      <= 1'b0;
              armed[i]     <= 1'b0;
            end
            if (disp_valid && disp_idx == IDX_W'(i)) begin
              bus.core_start[i] <= 1'b1;
              nonce_q[i]        <= next_nonce;
              busy[i]           <= 1'b1;
              armed[i]          <= 1'b0;
            end
            if (wr_valid && wr_idx == IDX_W'(i)) begin
              bus.mem_we         <= 1'b1;
              bus.mem_addr       <= base_addr + res_nonce[i];
              bus.mem_write_data <= res_data[i];
              res_valid[i]       <= 1'b0;
            end
          end
          if (disp_valid) next_nonce <= next_nonce + 32'd1;
          if (wr_valid) write_count <= write_count + 32'd1;
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Directed bench: behavioural cores with programmable latency, event monitor,
// and hand-derived cycle timelines for each run.
module tb_sha256_nonce_scheduler;

  localparam int NUM_CORES  = 4;
  localparam int NUM_NONCES = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] output_addr;
  logic        done;
  logic        mem_clk;

  int test_count = 0;
  int fail_count = 0;

  sha256_nonce_scheduler_if #(.NUM_CORES(NUM_CORES)) bus ();

  sha256_nonce_scheduler #(
    .NUM_CORES  (NUM_CORES),
    .NUM_NONCES (NUM_NONCES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .output_addr (output_addr),
    .done        (done),
    .mem_clk     (mem_clk),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cores: done drops the cycle after start is sampled, rises after lat cycles.
  int                   lat       [NUM_CORES] = '{default: 5};
  int                   cnt       [NUM_CORES] = '{default: 0};
  logic [31:0]          job_nonce [NUM_CORES] = '{default: 32'd0};
  logic [31:0]          m_h0      [NUM_CORES] = '{default: 32'd0};
  logic [NUM_CORES-1:0] m_done = '1;

  always @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (bus.core_start[i]) begin
        m_done[i]    <= 1'b0;
        cnt[i]       <= lat[i];
        job_nonce[i] <= bus.core_nonce[i*32 +: 32];
        m_h0[i]      <= 32'hDEAD_0000;
      end else if (!m_done[i]) begin
        if (cnt[i] == 1) begin
          m_done[i] <= 1'b1;
          m_h0[i]   <= 32'hA000_0000 + job_nonce[i];
        end
        cnt[i] <= cnt[i] - 1;
      end
    end
  end

  assign bus.core_done = m_done;

  always_comb begin
    bus.core_h0 = '0;
    for (int i = 0; i < NUM_CORES; i++) bus.core_h0[i*32 +: 32] = m_h0[i];
  end

  int          start_cyc = 0;
  logic [15:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_rel_q  [$];
  int          st_core_q [$];
  int          st_nonce_q[$];
  int          st_rel_q  [$];

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we) begin
        wr_addr_q.push_back(bus.mem_addr);
        wr_data_q.push_back(bus.mem_write_data);
        wr_rel_q.push_back(cyc - start_cyc);
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (bus.core_start[i]) begin
          st_core_q.push_back(i);
          st_nonce_q.push_back(int'(bus.core_nonce[i*32 +: 32]));
          st_rel_q.push_back(cyc - start_cyc);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Launches a run; poke fires a stray start mid-run that must be ignored.
  task automatic applyStimulus(input logic [15:0] base, input bit poke, output int done_rel);
    @(negedge clk);
    output_addr = base;
    start       = 1'b1;
    start_cyc   = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_fall", {31'd0, done}, 32'd0);
    done_rel = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (poke && k == 5) begin
        start       = 1'b1;
        output_addr = 16'h0BAD;
      end
      if (poke && k == 6) begin
        start       = 1'b0;
        output_addr = base;
      end
      if (done) begin
        done_rel = k;
        break;
      end
    end
  endtask

  int exp_core [NUM_NONCES] = '{0, 1, 2, 3, 0, 1};
  int exp_wr   [NUM_NONCES];
  int exp_st   [NUM_NONCES];

  task automatic checkRun(input string name, input logic [15:0] base, input int wr_off,
                          input int st_off, input int exp_done, input int done_rel);
    int          n_wr;
    int          n_st;
    logic [15:0] ea;
    n_wr = wr_addr_q.size() - wr_off;
    n_st = st_core_q.size() - st_off;
    checkOutput({name, "_nwrites"}, n_wr, NUM_NONCES);
    checkOutput({name, "_nstarts"}, n_st, NUM_NONCES);
    for (int j = 0; j < NUM_NONCES && j < n_wr; j++) begin
      ea = base + 16'(j);
      checkOutput($sformatf("%s_wr%0d_addr", name, j), {16'd0, wr_addr_q[wr_off+j]}, {16'd0, ea});
      checkOutput($sformatf("%s_wr%0d_data", name, j), wr_data_q[wr_off+j], 32'hA000_0000 + j);
      checkOutput($sformatf("%s_wr%0d_cycle", name, j), wr_rel_q[wr_off+j], exp_wr[j]);
    end
    for (int j = 0; j < NUM_NONCES && j < n_st; j++) begin
      checkOutput($sformatf("%s_st%0d_core", name, j), st_core_q[st_off+j], exp_core[j]);
      checkOutput($sformatf("%s_st%0d_nonce", name, j), st_nonce_q[st_off+j], j);
      checkOutput($sformatf("%s_st%0d_cycle", name, j), st_rel_q[st_off+j], exp_st[j]);
    end
    checkOutput({name, "_done_cycle"}, done_rel, exp_done);
  endtask

  int wr_off;
  int st_off;
  int done_rel;

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    output_addr = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("rst_done", {31'd0, done}, 32'd1);
    checkOutput("rst_core_start", {28'd0, bus.core_start}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    checkOutput("rst_mem_data", bus.mem_write_data, 32'd0);
    checkOutput("rst_nonce0", bus.core_nonce[31:0], 32'd0);
    checkOutput("mem_clk", {31'd0, mem_clk}, {31'd0, clk});
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_done", {31'd0, done}, 32'd1);

    $display("[TB] run A: equal latency, stray start mid-run");
    exp_wr = '{9, 10, 11, 12, 18, 19};
    exp_st = '{1, 2, 3, 4, 10, 11};
    wr_off = wr_addr_q.size();
    st_off = st_core_q.size();
    applyStimulus(16'h0100, 1'b1, done_rel);
    checkRun("runA", 16'h0100, wr_off, st_off, 21, done_rel);

    $display("[TB] run B: cores 0 and 1 complete together");
    lat    = '{6, 5, 5, 5};
    exp_wr = '{10, 11, 12, 13, 20, 21};
    exp_st = '{1, 2, 3, 4, 11, 12};
    wr_off = wr_addr_q.size();
    st_off = st_core_q.size();
    applyStimulus(16'h0200, 1'b0, done_rel);
    checkRun("runB", 16'h0200, wr_off, st_off, 23, done_rel);

    $display("[TB] run C: address wrap");
    lat    = '{5, 5, 5, 5};
    exp_wr = '{9, 10, 11, 12, 18, 19};
    exp_st = '{1, 2, 3, 4, 10, 11};
    wr_off = wr_addr_q.size();
    st_off = st_core_q.size();
    applyStimulus(16'hFFFE, 1'b0, done_rel);
    checkRun("runC", 16'hFFFE, wr_off, st_off, 21, done_rel);

    $display("[TB] run D: reset with three cores busy");
    @(negedge clk);
    output_addr = 16'h0300;
    start       = 1'b1;
    start_cyc   = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_done", {31'd0, done}, 32'd1);
    checkOutput("midrst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("midrst_core_start", {28'd0, bus.core_start}, 32'd0);
    for (int i = 0; i < NUM_CORES; i++) begin
      checkOutput($sformatf("midrst_nonce%0d", i), bus.core_nonce[i*32 +: 32], 32'd0);
    end
    reset  = 1'b0;
    wr_off = wr_addr_q.size();
    st_off = st_core_q.size();
    repeat (12) @(negedge clk);
    checkOutput("midrst_no_write", wr_addr_q.size() - wr_off, 32'd0);
    checkOutput("midrst_no_start", st_core_q.size() - st_off, 32'd0);
    wr_off = wr_addr_q.size();
    st_off = st_core_q.size();
    applyStimulus(16'h0300, 1'b0, done_rel);
    checkRun("runD", 16'h0300, wr_off, st_off, 21, done_rel);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
